// File: rtl/fetch_if.sv
// Fetch stage bus: branch/stall control from downstream, instruction memory
// address/data, and the registered IR bundle handed to decode.
interface fetch_if #(
  parameter int ADDR_W = 5,
  parameter int INST_W = 16
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic [ADDR_W-1:0] pc_addr;
  logic [INST_W-1:0] inst_in;
  logic [INST_W-1:0] ir_out;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic              halted;

  // Environment side: decode control plus instruction memory data.
  modport master (
    output stall, branch_taken, branch_target, inst_in,
    input  pc_addr, ir_out, ir_pc, ir_valid, halted
  );

  // Fetch unit side.
  modport slave (
    input  stall, branch_taken, branch_target, inst_in,
    output pc_addr, ir_out, ir_pc, ir_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches memory data into the IR,
// and handles stall, branch redirect (one-bubble flush) and halt.
module fetch_unit #(
  parameter int          ADDR_W  = 5,
  parameter int          INST_W  = 16,
  parameter logic [2:0]  HALT_OP = 3'b111
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.slave bus
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              valid;
  } ir_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  ir_t               ir;
  logic              halted_q;

  logic              is_halt;
  assign is_halt = (bus.inst_in[INST_W-1 -: 3] == HALT_OP);

  // PC, IR and state update; branch beats stall beats the normal state action.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= '0;
      ir       <= '0;
      halted_q <= 1'b0;
    end else if (bus.branch_taken) begin
      // Redirect squashes whatever is in flight, including a pending halt;
      // the stale IR payload is left in place but marked as a bubble.
      pc       <= bus.branch_target;
      ir.valid <= 1'b0;
      state    <= RUN;
      halted_q <= 1'b0;
    end else if (!bus.stall) begin
      case (state)
        RUN: begin
          ir.inst  <= bus.inst_in;
          ir.pc    <= pc;
          ir.valid <= 1'b1;
          if (is_halt) begin
            // Halt instruction itself is delivered; PC parks on it.
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            pc <= pc + ADDR_W'(1);
          end
        end
        HALT: ir.valid <= 1'b0;
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_addr  = pc;
  assign bus.ir_out   = ir.inst;
  assign bus.ir_pc    = ir.pc;
  assign bus.ir_valid = ir.valid;
  assign bus.halted   = halted_q;

endmodule
